// File: rtl/gat_pkg.sv
// Shared GAT accelerator definitions: default feature geometry, fetcher FSM states
// and a width helper that never returns zero.
package gat_pkg;

  localparam int GAT_NEW_FEATURE_WIDTH = 32;
  localparam int GAT_NUM_FEATURE_OUT   = 16;
  localparam int GAT_NUM_SUBGRAPHS     = 2708;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/feature_fetcher_if.sv
// BRAM port-B read bus plus the assembled-vector valid/ready stream of the
// feature fetcher; master is the fetcher, slave is BRAM + consumer.
interface feature_fetcher_if #(
  parameter int NEW_FEATURE_WIDTH = gat_pkg::GAT_NEW_FEATURE_WIDTH,
  parameter int NUM_FEATURE_OUT   = gat_pkg::GAT_NUM_FEATURE_OUT,
  parameter int NUM_SUBGRAPHS     = gat_pkg::GAT_NUM_SUBGRAPHS
);
  localparam int ADDR_W = gat_pkg::clog2_min1(NUM_SUBGRAPHS * NUM_FEATURE_OUT);
  localparam int IDX_W  = gat_pkg::clog2_min1(NUM_SUBGRAPHS);

  logic [ADDR_W-1:0]                          feat_bram_addrb;
  logic                                       feat_bram_enb;
  logic [NEW_FEATURE_WIDTH-1:0]               feat_bram_doutb;
  logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0] feat_out;
  logic                                       feat_out_vld;
  logic                                       feat_out_rdy;
  logic [IDX_W-1:0]                           node_idx;

  modport master (
    output feat_bram_addrb, feat_bram_enb, feat_out, feat_out_vld, node_idx,
    input  feat_bram_doutb, feat_out_rdy
  );

  modport slave (
    input  feat_bram_addrb, feat_bram_enb, feat_out, feat_out_vld, node_idx,
    output feat_bram_doutb, feat_out_rdy
  );

endinterface

// File: rtl/bram_rd_pipe.sv
// Tag delay line matching the BRAM read latency: carries the read-valid bit and
// the word's lane index so returning data can be steered without re-deriving it.
module bram_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_p0,
  input  logic [IDX_W-1:0] idx_p0,
  output logic             vld_out,
  output logic [IDX_W-1:0] idx_out
);

  logic [DEPTH-1:0] vld_p;
  logic [IDX_W-1:0] idx_p [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) idx_p[i] <= '0;
    end else begin
      vld_p[0] <= vld_p0;
      idx_p[0] <= idx_p0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
    end
  end

  assign vld_out = vld_p[DEPTH-1];
  assign idx_out = idx_p[DEPTH-1];

endmodule

// File: rtl/feature_fetcher.sv
// Streams every node's feature words out of BRAM and assembles them into one wide
// vector per node. Optional build macro FEATURE_FETCHER_RELU_EN clamps negative words to 0.
module feature_fetcher
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH = GAT_NEW_FEATURE_WIDTH,
  parameter int NUM_FEATURE_OUT   = GAT_NUM_FEATURE_OUT,
  parameter int NUM_SUBGRAPHS     = GAT_NUM_SUBGRAPHS,
  parameter int BRAM_RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  feature_fetcher_if.master bus
);

  localparam int W      = NEW_FEATURE_WIDTH;
  localparam int NFO    = NUM_FEATURE_OUT;
  localparam int NSG    = NUM_SUBGRAPHS;
  localparam int TOTAL  = NSG * NFO;
  localparam int ADDR_W = clog2_min1(TOTAL);
  localparam int IDX_W  = clog2_min1(NSG);
  localparam int K_W    = $clog2(NFO);
  localparam int VEC_W  = NFO * W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0]  LAST_NODE = IDX_W'(NSG - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(NFO - 1);

  function automatic logic signed [W-1:0] relu_word(input logic signed [W-1:0] w);
`ifdef FEATURE_FETCHER_RELU_EN
    return (w < 0) ? '0 : w;
`else
    return w;
`endif
  endfunction

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        alloc, alloc_nxt;
  logic              issue, slot_ok, fire, done_nxt;
  logic [K_W-1:0]    word_k;

  logic              rd_vld;
  logic [K_W-1:0]    rd_k;
  logic [K_W-1:0]    lane;
  logic signed [W-1:0] word_in;
  logic              complete, out_free;

  logic [VEC_W-1:0]  asm_vec, asm_merged, out_vec;
  logic              asm_full, out_vld;
  logic [IDX_W-1:0]  out_idx;

  assign word_k = addr[K_W-1:0];
  assign fire   = out_vld & bus.feat_out_rdy;
  // A new node may start issuing only if it will own an entry (assembly or output)
  // by the time its words return; words inside an already-owned node always go.
  assign slot_ok = (word_k != '0) || (alloc != 2'd2) || fire;

  // The first read overlaps the start cycle so the first vector lands
  // NUM_FEATURE_OUT + BRAM_RD_LAT cycles after start.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          issue     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (slot_ok) begin
          issue = 1'b1;
          if (addr == LAST_ADDR) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fire && out_idx == LAST_NODE) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alloc_nxt = alloc;
    if (issue && word_k == '0) alloc_nxt = alloc_nxt + 2'd1;
    if (fire)                  alloc_nxt = alloc_nxt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      addr  <= '0;
      alloc <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      alloc <= alloc_nxt;
      done  <= done_nxt;
      if (done_nxt)                         addr <= '0;
      else if (issue && addr != LAST_ADDR)  addr <= addr + 1'b1;
    end
  end

  // ---- read issue / BRAM latency boundary ----
  bram_rd_pipe #(
    .DEPTH (BRAM_RD_LAT),
    .IDX_W (K_W)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_p0  (issue),
    .idx_p0  (word_k),
    .vld_out (rd_vld),
    .idx_out (rd_k)
  );

  // ---- returning data: assembly and output entries ----
  assign word_in  = relu_word(signed'(bus.feat_bram_doutb));
  assign lane     = LAST_K - rd_k;
  assign complete = rd_vld && (rd_k == LAST_K);
  assign out_free = !out_vld || fire;

  always_comb begin
    asm_merged = asm_vec;
    if (rd_vld) asm_merged[int'(lane)*W +: W] = word_in;
  end

  always_ff @(posedge clk) begin
    if (rd_vld) asm_vec <= asm_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_full <= 1'b0;
      out_vld  <= 1'b0;
      out_vec  <= '0;
      out_idx  <= '0;
    end else begin
      if (asm_full && out_free) begin
        out_vec  <= asm_vec;
        out_vld  <= 1'b1;
        asm_full <= 1'b0;
      end else if (complete && out_free) begin
        out_vec <= asm_merged;
        out_vld <= 1'b1;
      end else begin
        if (complete) asm_full <= 1'b1;
        if (fire)     out_vld  <= 1'b0;
      end
      if (fire) out_idx <= (out_idx == LAST_NODE) ? '0 : out_idx + 1'b1;
    end
  end

  assign bus.feat_bram_enb   = issue;
  assign bus.feat_bram_addrb = addr;
  assign bus.feat_out        = out_vec;
  assign bus.feat_out_vld    = out_vld;
  assign bus.node_idx        = out_idx;
  assign busy                = (state != ST_IDLE);

endmodule

// File: tb/tb_feature_fetcher.sv
// Bench for feature_fetcher: 4 words/node, 3 nodes, 2-cycle BRAM; reference
// vectors are rebuilt from the memory contents and the lane-reversal rule.
module tb_feature_fetcher;

  localparam int W     = 32;
  localparam int NFO   = 4;
  localparam int NSG   = 3;
  localparam int LAT   = 2;
  localparam int TOTAL = NFO * NSG;

`ifdef FEATURE_FETCHER_RELU_EN
  localparam logic [W-1:0] NEG_EXP = 32'h0000_0000;
`else
  localparam logic [W-1:0] NEG_EXP = 32'hFFFF_FFF0;
`endif

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  feature_fetcher_if #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(NFO), .NUM_SUBGRAPHS(NSG)) bus ();

  feature_fetcher #(
    .NEW_FEATURE_WIDTH (W),
    .NUM_FEATURE_OUT   (NFO),
    .NUM_SUBGRAPHS     (NSG),
    .BRAM_RD_LAT       (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] mem [16];
  logic [W-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (bus.feat_bram_enb) rd1 <= mem[bus.feat_bram_addrb];
    rd2 <= rd1;
  end
  assign bus.feat_bram_doutb = rd2;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [NFO*W-1:0] dv_vec[$];
  int               dv_idx[$];
  int               dv_cyc[$];
  int               addr_log[$];
  int               done_log[$];
  bit               enb_hist[$];
  bit               vld_hist[$];
  bit               busy_hist[$];
  logic [NFO*W-1:0] feat_hist[$];
  int               idx_hist[$];

  function automatic logic [NFO*W-1:0] exp_vec(input int n);
    logic [NFO*W-1:0] v;
    logic [W-1:0] w;
    v = '0;
    for (int k = 0; k < NFO; k++) begin
      w = mem[n*NFO + k];
`ifdef FEATURE_FETCHER_RELU_EN
      if (w[W-1]) w = '0;
`endif
      v[(NFO-1-k)*W +: W] = w;
    end
    return v;
  endfunction

  task automatic clear_logs();
    dv_vec.delete(); dv_idx.delete(); dv_cyc.delete(); addr_log.delete();
    done_log.delete(); enb_hist.delete(); vld_hist.delete(); busy_hist.delete();
    feat_hist.delete(); idx_hist.delete();
    cyc = -1;
  endtask

  task automatic mem_linear();
    for (int i = 0; i < 16; i++) mem[i] = W'(i);
  endtask

  // One cycle: drive inputs at the falling edge, then record what the DUT shows.
  task automatic step(input logic st, input logic r);
    @(negedge clk);
    start = st;
    bus.feat_out_rdy = r;
    #1;
    cyc++;
    enb_hist.push_back(bus.feat_bram_enb);
    vld_hist.push_back(bus.feat_out_vld);
    busy_hist.push_back(busy);
    feat_hist.push_back(bus.feat_out);
    idx_hist.push_back(int'(bus.node_idx));
    if (bus.feat_bram_enb) addr_log.push_back(int'(bus.feat_bram_addrb));
    if (bus.feat_out_vld && r) begin
      dv_vec.push_back(bus.feat_out);
      dv_idx.push_back(int'(bus.node_idx));
      dv_cyc.push_back(cyc);
    end
    if (done) done_log.push_back(cyc);
  endtask

  // mode 0: rdy high, 1: rdy low until cycle hold, 2: rdy toggles, 3: random rdy
  task automatic run_pass(input int mode, input int hold, input int restart, output bit finished);
    logic r;
    clear_logs();
    finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (c >= hold);
        2:       r = c[0];
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      step((c == 0) || (c == restart), r);
      if (done_log.size() > 0) finished = 1'b1;
    end
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bus.feat_out_rdy = 1'b0;
    mem_linear();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.feat_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus.feat_out_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bus.feat_bram_enb !== 1'b0) begin errors++; $display("FAIL reset_enb got %b want 0", bus.feat_bram_enb); end
    checks++; if (bus.feat_bram_addrb !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.feat_bram_addrb); end
    checks++; if (bus.node_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.node_idx); end
    checks++; if (bus.feat_out !== '0) begin errors++; $display("FAIL reset_feat got %h want 0", bus.feat_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.feat_bram_enb !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got enb=%b busy=%b want 0 0", bus.feat_bram_enb, busy); end
  endtask

  task automatic test_basic();
    bit fin;
    logic [NFO*W-1:0] first;
    mem_linear();
    run_pass(0, 0, -1, fin);
    checks++; if (!fin) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (addr_log.size() != TOTAL) begin errors++; $display("FAIL basic_reads got %0d want %0d", addr_log.size(), TOTAL); end
    for (int i = 0; i < addr_log.size() && i < TOTAL; i++) begin
      checks++; if (addr_log[i] != i) begin errors++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, addr_log[i], i); end
    end
    checks++; if (dv_vec.size() != NSG) begin errors++; $display("FAIL basic_count got %0d want %0d", dv_vec.size(), NSG); end
    for (int i = 0; i < dv_vec.size() && i < NSG; i++) begin
      checks++; if (dv_idx[i] != i) begin errors++; $display("FAIL basic_idx[%0d] got %0d want %0d", i, dv_idx[i], i); end
      checks++; if (dv_vec[i] !== exp_vec(i)) begin errors++; $display("FAIL basic_vec[%0d] got %h want %h", i, dv_vec[i], exp_vec(i)); end
      checks++; if (dv_cyc[i] != NFO + LAT + i*NFO) begin errors++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, dv_cyc[i], NFO + LAT + i*NFO); end
    end
    if (dv_vec.size() > 0) begin
      first = dv_vec[0];
      checks++; if (first !== {32'd0, 32'd1, 32'd2, 32'd3}) begin errors++; $display("FAIL basic_lanes got %h want 00000000000000010000000200000003", first); end
    end
    checks++; if (done_log.size() != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_log.size()); end
    if (done_log.size() > 0 && dv_cyc.size() == NSG) begin
      checks++; if (done_log[0] != dv_cyc[NSG-1] + 1) begin errors++; $display("FAIL basic_done_cycle got %0d want %0d", done_log[0], dv_cyc[NSG-1] + 1); end
      checks++; if (busy_hist[done_log[0]] !== 1'b0 || busy_hist[done_log[0]-1] !== 1'b1) begin errors++; $display("FAIL basic_busy_end got %b%b want 10", busy_hist[done_log[0]-1], busy_hist[done_log[0]]); end
    end
    checks++; if (busy_hist[1] !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_hist[1]); end
  endtask

  task automatic test_backpressure();
    bit fin;
    int rd20;
    mem_linear();
    run_pass(1, 20, -1, fin);
    checks++; if (!fin) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    rd20 = 0;
    for (int c = 0; c < 20; c++) if (enb_hist[c]) rd20++;
    checks++; if (rd20 != 2*NFO) begin errors++; $display("FAIL bp_reads got %0d want %0d", rd20, 2*NFO); end
    checks++; if (enb_hist[19] !== 1'b0) begin errors++; $display("FAIL bp_enb_stall got %b want 0", enb_hist[19]); end
    for (int c = NFO + LAT; c < 20; c++) begin
      checks++;
      if (vld_hist[c] !== 1'b1 || feat_hist[c] !== exp_vec(0) || idx_hist[c] != 0) begin
        errors++; $display("FAIL bp_hold[%0d] got vld=%b idx=%0d %h want vld=1 idx=0 %h", c, vld_hist[c], idx_hist[c], feat_hist[c], exp_vec(0));
      end
    end
    checks++; if (addr_log.size() != TOTAL) begin errors++; $display("FAIL bp_total_reads got %0d want %0d", addr_log.size(), TOTAL); end
    checks++; if (dv_vec.size() != NSG) begin errors++; $display("FAIL bp_count got %0d want %0d", dv_vec.size(), NSG); end
    for (int i = 0; i < dv_vec.size() && i < NSG; i++) begin
      checks++; if (dv_idx[i] != i || dv_vec[i] !== exp_vec(i)) begin errors++; $display("FAIL bp_vec[%0d] got idx=%0d %h want idx=%0d %h", i, dv_idx[i], dv_vec[i], i, exp_vec(i)); end
    end
  endtask

  task automatic test_restart_ignored();
    bit fin;
    mem_linear();
    run_pass(0, 0, 3, fin);
    checks++; if (!fin) begin errors++; $display("FAIL restart_timeout got no done want done"); end
    checks++; if (addr_log.size() != TOTAL) begin errors++; $display("FAIL restart_reads got %0d want %0d", addr_log.size(), TOTAL); end
    for (int i = 0; i < addr_log.size() && i < TOTAL; i++) begin
      checks++; if (addr_log[i] != i) begin errors++; $display("FAIL restart_addr[%0d] got %0d want %0d", i, addr_log[i], i); end
    end
    checks++; if (done_log.size() != 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", done_log.size()); end
    checks++; if (dv_vec.size() != NSG) begin errors++; $display("FAIL restart_count got %0d want %0d", dv_vec.size(), NSG); end
  endtask

  task automatic test_reset_mid();
    bit fin;
    int seen_vld;
    mem_linear();
    clear_logs();
    step(1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) step(1'b0, 1'b0);
    checks++; if (vld_hist[7] !== 1'b1) begin errors++; $display("FAIL midrst_pre_vld got %b want 1", vld_hist[7]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.feat_out_vld !== 1'b0 || bus.feat_out !== '0 || bus.node_idx !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || bus.feat_bram_enb !== 1'b0 || bus.feat_bram_addrb !== '0) begin
      errors++;
      $display("FAIL midrst_async got vld=%b feat=%h idx=%0d busy=%b done=%b enb=%b addr=%0d want all 0",
               bus.feat_out_vld, bus.feat_out, bus.node_idx, busy, done, bus.feat_bram_enb, bus.feat_bram_addrb);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    for (int c = 0; c < 15; c++) step(1'b0, 1'b1);
    seen_vld = 0;
    for (int c = 0; c < 15; c++) if (vld_hist[c]) seen_vld++;
    checks++; if (seen_vld != 0 || addr_log.size() != 0) begin errors++; $display("FAIL midrst_quiet got vld_cycles=%0d reads=%0d want 0 0", seen_vld, addr_log.size()); end
    run_pass(0, 0, -1, fin);
    checks++; if (!fin) begin errors++; $display("FAIL midrst_timeout got no done want done"); end
    checks++; if (addr_log.size() == 0 || addr_log[0] != 0) begin errors++; $display("FAIL midrst_first_addr got size=%0d want addr 0", addr_log.size()); end
    checks++; if (dv_vec.size() != NSG) begin errors++; $display("FAIL midrst_count got %0d want %0d", dv_vec.size(), NSG); end
    for (int i = 0; i < dv_vec.size() && i < NSG; i++) begin
      checks++; if (dv_idx[i] != i || dv_vec[i] !== exp_vec(i)) begin errors++; $display("FAIL midrst_vec[%0d] got idx=%0d %h want idx=%0d %h", i, dv_idx[i], dv_vec[i], i, exp_vec(i)); end
    end
  endtask

  task automatic test_relu_random();
    bit fin;
    logic [NFO*W-1:0] v;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'hFFFF_FFF0;
    mem[5] = 32'h8000_0000;
    mem[6] = 32'h7FFF_FFFF;
    run_pass(3, 0, -1, fin);
    checks++; if (!fin) begin errors++; $display("FAIL relu_timeout got no done want done"); end
    checks++; if (dv_vec.size() != NSG) begin errors++; $display("FAIL relu_count got %0d want %0d", dv_vec.size(), NSG); end
    for (int i = 0; i < dv_vec.size() && i < NSG; i++) begin
      checks++; if (dv_idx[i] != i || dv_vec[i] !== exp_vec(i)) begin errors++; $display("FAIL relu_vec[%0d] got idx=%0d %h want idx=%0d %h", i, dv_idx[i], dv_vec[i], i, exp_vec(i)); end
    end
    if (dv_vec.size() > 0) begin
      v = dv_vec[0];
      checks++; if (v[NFO*W-1 -: W] !== NEG_EXP) begin errors++; $display("FAIL relu_neg_lane got %h want %h", v[NFO*W-1 -: W], NEG_EXP); end
    end
  endtask

  task automatic test_rdy_toggle();
    bit fin;
    mem_linear();
    run_pass(2, 0, -1, fin);
    checks++; if (!fin) begin errors++; $display("FAIL toggle_timeout got no done want done"); end
    checks++; if (dv_vec.size() != NSG) begin errors++; $display("FAIL toggle_count got %0d want %0d", dv_vec.size(), NSG); end
    for (int i = 0; i < dv_vec.size() && i < NSG; i++) begin
      checks++; if (dv_idx[i] != i || dv_vec[i] !== exp_vec(i)) begin errors++; $display("FAIL toggle_vec[%0d] got idx=%0d %h want idx=%0d %h", i, dv_idx[i], dv_vec[i], i, exp_vec(i)); end
    end
    checks++; if (addr_log.size() != TOTAL || done_log.size() != 1) begin errors++; $display("FAIL toggle_totals got reads=%0d dones=%0d want %0d 1", addr_log.size(), done_log.size(), TOTAL); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_relu_random();
    test_rdy_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feature_fetcher.md
FEATURE_FETCHER -- requirements
Module: feature_fetcher

Interface
REQ-001 SHALL have parameter NEW_FEATURE_WIDTH, default 32, width of one feature word.
REQ-002 SHALL have parameter NUM_FEATURE_OUT, default 16, words per node vector (power of 2, >=2).
REQ-003 SHALL have parameter NUM_SUBGRAPHS, default 2708, number of node vectors to fetch.
REQ-004 SHALL have parameter BRAM_RD_LAT, default 2, BRAM port-B read latency in cycles (>=1).
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, single-cycle pulse that begins a full fetch pass.
REQ-008 SHALL have port feat_bram_addrb, output, clog2(NUM_SUBGRAPHS*NUM_FEATURE_OUT), BRAM read address.
REQ-009 SHALL have port feat_bram_enb, output, 1, BRAM read enable.
REQ-010 SHALL have port feat_bram_doutb, input, NEW_FEATURE_WIDTH, BRAM read data, valid BRAM_RD_LAT cycles after enb.
REQ-011 SHALL have port feat_out, output, NUM_FEATURE_OUT x NEW_FEATURE_WIDTH packed, assembled node vector.
REQ-012 SHALL have port feat_out_vld, output, 1, feat_out valid.
REQ-013 SHALL have port feat_out_rdy, input, 1, consumer accepts feat_out.
REQ-014 SHALL have port node_idx, output, clog2(NUM_SUBGRAPHS), index of node on feat_out.
REQ-015 SHALL have ports busy (output, 1, pass in progress) and done (output, 1, one-cycle pulse at pass end).

Function
REQ-016 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE; start in IDLE enters FETCH; start outside IDLE is ignored.
REQ-017 SHALL in FETCH issue one read per cycle (enb=1) at consecutive addresses from 0, only while the assembly stage is free or completes this cycle.
REQ-018 SHALL place the word read from address n*NUM_FEATURE_OUT+k into lane NUM_FEATURE_OUT-1-k of node n's vector (inverse of writer packing).
REQ-019 SHALL track returning data with a BRAM_RD_LAT-deep valid shift register; data is captured only when its tag is valid.
REQ-020 SHALL keep a two-entry structure: assembly register plus output register; a complete vector moves to output when output is empty or accepted that cycle.
REQ-021 SHALL transfer a vector when feat_out_vld && feat_out_rdy; feat_out, node_idx stable while vld && !rdy.
REQ-022 SHALL stall issuing reads (enb=0, address held) whenever both assembly and output entries are occupied or reserved by in-flight reads.
REQ-023 SHALL enter DRAIN after issuing address NUM_SUBGRAPHS*NUM_FEATURE_OUT-1; no further reads, no wrap-around.
REQ-024 SHALL pulse done one cycle after the last vector (node_idx=NUM_SUBGRAPHS-1) is accepted, and return to IDLE that cycle.
REQ-025 SHALL achieve, with feat_out_rdy held high, first feat_out_vld exactly NUM_FEATURE_OUT+BRAM_RD_LAT cycles after start, and one vector every NUM_FEATURE_OUT cycles thereafter.
REQ-026 SHALL assert busy in FETCH and DRAIN only.

Reset
REQ-027 SHALL on rst_n low asynchronously set FSM=IDLE, all outputs 0, address/counters/valid pipe 0; data in flight is discarded.
REQ-028 SHALL after reset mid-pass require a new start; BRAM data returning after reset is ignored.

Configuration
REQ-029 SHALL, with FEATURE_FETCHER_RELU_EN defined, clamp each captured word (signed) to 0 if negative before packing; without it, words pass unmodified.

Structure
REQ-030 SHALL take NEW_FEATURE_WIDTH, NUM_FEATURE_OUT, NUM_SUBGRAPHS defaults and the FSM state enum typedef from shared package gat_pkg.
REQ-031 SHALL instantiate one sub-module bram_rd_pipe (parameterised valid/lane-index delay line of depth BRAM_RD_LAT).

Verification (NUM_FEATURE_OUT=4, NUM_SUBGRAPHS=3, BRAM_RD_LAT=2, BRAM word = address)
REQ-032 SHALL cover: start, rdy=1 -> node0 feat_out lanes{3,2,1,0}={0,1,2,3} at cycle 6; node1 {4,5,6,7} at cycle 10; done after node2.
REQ-033 SHALL cover: rdy=0 for 20 cycles after start -> exactly 8 reads issued, then enb=0; feat_out holds node0; release yields node1, node2 in order.
REQ-034 SHALL cover: start pulsed again at cycle 3 -> ignored; exactly 12 reads, one done pulse.
REQ-035 SHALL cover: rst_n low at cycle 7 -> all outputs 0 asynchronously; no vld after release until new start; next pass restarts at address 0.
REQ-036 SHALL cover: FEATURE_FETCHER_RELU_EN defined, BRAM word 0xFFFFFFF0 -> lane value 0; undefined -> 0xFFFFFFF0.
REQ-037 SHALL cover: rdy toggling every cycle -> all 3 vectors delivered once, correct node_idx 0,1,2, no data loss.
